// File: rtl/ofs_fim_pcie_ss_cpl_credit_meter_if.sv
// Request/release bus for the completion credit meter.
// master: requesters + completion retire path; slave: the meter.
interface ofs_fim_pcie_ss_cpl_credit_meter_if #(
  parameter int NUM_CH = 4,
  parameter int HW     = 9,
  parameter int DW     = 11,
  parameter int CW     = 2
);
  logic [NUM_CH-1:0]         req_valid;
  logic [NUM_CH-1:0][HW-1:0] req_hdr;
  logic [NUM_CH-1:0][DW-1:0] req_data;
  logic [NUM_CH-1:0]         req_grant;

  logic                      rel_valid;
  logic [CW-1:0]             rel_chan;
  logic [HW-1:0]             rel_hdr;
  logic [DW-1:0]             rel_data;
  logic                      rel_done;

  modport master (
    output req_valid,
    output req_hdr,
    output req_data,
    input  req_grant,
    output rel_valid,
    output rel_chan,
    output rel_hdr,
    output rel_data,
    output rel_done
  );

  modport slave (
    input  req_valid,
    input  req_hdr,
    input  req_data,
    output req_grant,
    input  rel_valid,
    input  rel_chan,
    input  rel_hdr,
    input  rel_data,
    input  rel_done
  );
endinterface

// File: rtl/ofs_fim_pcie_ss_cpl_credit_meter.sv
// Multi-channel completion credit meter: RR grant of hdr/data credits,
// per-channel outstanding cap, sticky overflow/underflow/oversize flags.
// Ports: clk, rst_n (sync, active low); bus (slave: req_*/rel_*);
// avail_hdr/avail_data, ch_outst (registered); err_* (sticky).
module ofs_fim_pcie_ss_cpl_credit_meter #(
  parameter int NUM_CH       = 4,
  parameter int HDR_CREDITS  = 256,
  parameter int DATA_CREDITS = 1024,
  parameter int MAX_OUTST    = 64,
  localparam int HW = $clog2(HDR_CREDITS + 1),
  localparam int DW = $clog2(DATA_CREDITS + 1),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OW = $clog2(MAX_OUTST + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ofs_fim_pcie_ss_cpl_credit_meter_if.slave bus,
  output logic [HW-1:0]             avail_hdr,
  output logic [DW-1:0]             avail_data,
  output logic [NUM_CH-1:0][OW-1:0] ch_outst,
  output logic                      err_overflow,
  output logic                      err_underflow,
  output logic                      err_oversize
);

  localparam logic [HW-1:0] HCAP = HW'(HDR_CREDITS);
  localparam logic [DW-1:0] DCAP = DW'(DATA_CREDITS);
  localparam logic [OW-1:0] OCAP = OW'(MAX_OUTST);

  logic [HW-1:0]             avail_hdr_q, avail_hdr_d;
  logic [DW-1:0]             avail_data_q, avail_data_d;
  logic [NUM_CH-1:0][OW-1:0] outst_q, outst_d;
  logic [CW-1:0]             ptr_q, ptr_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;
  logic                      osz_q, osz_d;

  logic [NUM_CH-1:0]         size_bad;
  logic [NUM_CH-1:0]         elig;
  logic                      found;
  logic [CW-1:0]             gnt_idx;
  logic [NUM_CH-1:0]         grant;

  logic [HW-1:0]             g_hdr, r_hdr;
  logic [DW-1:0]             g_data, r_data;
  logic [HW:0]               hsum;
  logic [DW:0]               dsum;
  logic                      ovf_now;
  logic                      unf_now;
  logic                      osz_now;

  // Eligibility uses registered counters only; a release this cycle
  // cannot fund a grant until the next cycle.
  always_comb begin
    size_bad = '0;
    elig     = '0;
    osz_now  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      size_bad[c] = (bus.req_hdr[c] == '0)
                 || (bus.req_hdr[c] > HCAP)
                 || (bus.req_data[c] > DCAP);
      elig[c] = bus.req_valid[c]
             && !size_bad[c]
             && (bus.req_hdr[c] <= avail_hdr_q)
             && (bus.req_data[c] <= avail_data_q)
             && (outst_q[c] < OCAP);
      if (bus.req_valid[c] && size_bad[c])
        osz_now = 1'b1;
    end
  end

  // Rotating priority: scan from ptr_q, wrapping, take the first hit.
  always_comb begin
    int k;
    k       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_CH)
        k = k - NUM_CH;
      if (!found && elig[k]) begin
        found   = 1'b1;
        gnt_idx = CW'(k);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (rst_n && found)
      grant = NUM_CH'(1) << gnt_idx;
  end

  assign bus.req_grant = grant;

  always_comb begin
    g_hdr  = '0;
    g_data = '0;
    if (rst_n && found) begin
      g_hdr  = bus.req_hdr[gnt_idx];
      g_data = bus.req_data[gnt_idx];
    end
    r_hdr  = bus.rel_valid ? bus.rel_hdr  : '0;
    r_data = bus.rel_valid ? bus.rel_data : '0;
  end

  // One extra bit of headroom: the grant never exceeds the registered
  // balance, so only the release side can push past capacity.
  always_comb begin
    hsum    = {1'b0, avail_hdr_q} + {1'b0, r_hdr} - {1'b0, g_hdr};
    dsum    = {1'b0, avail_data_q} + {1'b0, r_data} - {1'b0, g_data};
    ovf_now = 1'b0;
    if (hsum > {1'b0, HCAP}) begin
      avail_hdr_d = HCAP;
      ovf_now     = 1'b1;
    end else begin
      avail_hdr_d = hsum[HW-1:0];
    end
    if (dsum > {1'b0, DCAP}) begin
      avail_data_d = DCAP;
      ovf_now      = 1'b1;
    end else begin
      avail_data_d = dsum[DW-1:0];
    end
  end

  // Grant and retire on the same channel cancel out, so no underflow
  // is reported for that case even at zero outstanding.
  always_comb begin
    logic inc;
    logic dec;
    inc     = 1'b0;
    dec     = 1'b0;
    outst_d = outst_q;
    unf_now = bus.rel_valid && (int'(bus.rel_chan) >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      inc = grant[c];
      dec = bus.rel_valid && bus.rel_done
         && (int'(bus.rel_chan) == c);
      if (inc && !dec) begin
        outst_d[c] = outst_q[c] + OW'(1);
      end else if (dec && !inc) begin
        if (outst_q[c] == '0)
          unf_now = 1'b1;
        else
          outst_d[c] = outst_q[c] - OW'(1);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (int'(gnt_idx) == NUM_CH - 1)
        ptr_d = '0;
      else
        ptr_d = gnt_idx + CW'(1);
    end
    ovf_d = ovf_q | ovf_now;
    unf_d = unf_q | unf_now;
    osz_d = osz_q | osz_now;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avail_hdr_q  <= HCAP;
      avail_data_q <= DCAP;
      outst_q      <= '0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      osz_q        <= 1'b0;
    end else begin
      avail_hdr_q  <= avail_hdr_d;
      avail_data_q <= avail_data_d;
      outst_q      <= outst_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      osz_q        <= osz_d;
    end
  end

  assign avail_hdr     = avail_hdr_q;
  assign avail_data    = avail_data_q;
  assign ch_outst      = outst_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_oversize  = osz_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_cpl_credit_meter.sv
// Scenario bench for the completion credit meter.
// Grant expectations go through a queue; counters are checked directly.
module tb_ofs_fim_pcie_ss_cpl_credit_meter;

  localparam int NUM_CH       = 4;
  localparam int HDR_CREDITS  = 256;
  localparam int DATA_CREDITS = 1024;
  localparam int MAX_OUTST    = 64;
  localparam int HW = $clog2(HDR_CREDITS + 1);
  localparam int DW = $clog2(DATA_CREDITS + 1);
  localparam int CW = 2;
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic [HW-1:0]             avail_hdr;
  logic [DW-1:0]             avail_data;
  logic [NUM_CH-1:0][OW-1:0] ch_outst;
  logic err_overflow, err_underflow, err_oversize;

  always #5 clk = ~clk;

  ofs_fim_pcie_ss_cpl_credit_meter_if #(
    .NUM_CH(NUM_CH), .HW(HW), .DW(DW), .CW(CW)
  ) bus ();

  ofs_fim_pcie_ss_cpl_credit_meter #(
    .NUM_CH(NUM_CH),
    .HDR_CREDITS(HDR_CREDITS),
    .DATA_CREDITS(DATA_CREDITS),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .avail_hdr(avail_hdr),
    .avail_data(avail_data),
    .ch_outst(ch_outst),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .err_oversize(err_oversize)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [NUM_CH-1:0] gnt_q[$];
  logic [NUM_CH-1:0] exp_g;

  task automatic clear_in();
    bus.req_valid = '0;
    bus.req_hdr   = '0;
    bus.req_data  = '0;
    bus.rel_valid = 1'b0;
    bus.rel_chan  = '0;
    bus.rel_hdr   = '0;
    bus.rel_data  = '0;
    bus.rel_done  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    for (int c = 0; c < NUM_CH; c++) bus.req_hdr[c] = 9'd1;
    #1;
    n_checks++;
    if (bus.req_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 0000", bus.req_grant);
    end
    tick();
    tick();
    clear_in();
    rst_n = 1'b1;
    n_checks++;
    if (avail_hdr !== 9'd256 || avail_data !== 11'd1024) begin
      n_fail++;
      $display("FAIL reset_avail: got %0d/%0d want 256/1024",
               avail_hdr, avail_data);
    end
    n_checks++;
    if (ch_outst !== '0) begin
      n_fail++;
      $display("FAIL reset_outst: got %h want 0", ch_outst);
    end
    n_checks++;
    if ({err_overflow, err_underflow, err_oversize} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 000",
               {err_overflow, err_underflow, err_oversize});
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid[0] = 1'b1;
    bus.req_hdr[0]   = 9'd4;
    bus.req_data[0]  = 11'd16;
    gnt_q.push_back(4'b0001);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL single_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    clear_in();
    n_checks++;
    if (avail_hdr !== 9'd252 || avail_data !== 11'd1008
        || ch_outst[0] !== 7'd1) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d/%0d/%0d want 252/1008/1",
               avail_hdr, avail_data, ch_outst[0]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = 4'hF;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.req_hdr[c]  = 9'd1;
      bus.req_data[c] = 11'd1;
    end
    for (int i = 0; i < 8; i++) begin
      gnt_q.push_back(4'b0001 << (i % 4));
      #1;
      exp_g = gnt_q.pop_front();
      n_checks++;
      if (bus.req_grant !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", i, bus.req_grant, exp_g);
      end
      tick();
    end
    clear_in();
    n_checks++;
    if (avail_hdr !== 9'd248 || avail_data !== 11'd1016) begin
      n_fail++;
      $display("FAIL rr_avail: got %0d/%0d want 248/1016",
               avail_hdr, avail_data);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (ch_outst[c] !== 7'd2) begin
        n_fail++;
        $display("FAIL rr_outst%0d: got %0d want 2", c, ch_outst[c]);
      end
    end
  endtask

  task automatic test_release_timing();
    do_reset();
    bus.req_valid[0] = 1'b1;
    bus.req_hdr[0]   = 9'd253;
    bus.req_data[0]  = 11'd0;
    gnt_q.push_back(4'b0001);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL drain_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    clear_in();
    n_checks++;
    if (avail_hdr !== 9'd3) begin
      n_fail++;
      $display("FAIL drain_avail: got %0d want 3", avail_hdr);
    end
    bus.req_valid[1] = 1'b1;
    bus.req_hdr[1]   = 9'd4;
    bus.rel_valid    = 1'b1;
    bus.rel_chan     = 2'd0;
    bus.rel_hdr      = 9'd4;
    gnt_q.push_back(4'b0000);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL samecyc_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    bus.rel_valid = 1'b0;
    bus.rel_hdr   = '0;
    n_checks++;
    if (avail_hdr !== 9'd7) begin
      n_fail++;
      $display("FAIL rel_avail: got %0d want 7", avail_hdr);
    end
    gnt_q.push_back(4'b0010);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL nextcyc_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    clear_in();
    n_checks++;
    if (avail_hdr !== 9'd3) begin
      n_fail++;
      $display("FAIL after_avail: got %0d want 3", avail_hdr);
    end
  endtask

  task automatic test_outst_cap();
    do_reset();
    bus.req_valid[2] = 1'b1;
    bus.req_hdr[2]   = 9'd1;
    for (int i = 0; i < 64; i++) begin
      gnt_q.push_back(4'b0100);
      #1;
      exp_g = gnt_q.pop_front();
      n_checks++;
      if (bus.req_grant !== exp_g) begin
        n_fail++;
        $display("FAIL fill_grant%0d: got %b want %b", i, bus.req_grant, exp_g);
      end
      tick();
    end
    n_checks++;
    if (ch_outst[2] !== 7'd64 || avail_hdr !== 9'd192) begin
      n_fail++;
      $display("FAIL cap_cnt: got %0d/%0d want 64/192",
               ch_outst[2], avail_hdr);
    end
    bus.req_valid[3] = 1'b1;
    bus.req_hdr[3]   = 9'd1;
    for (int i = 0; i < 2; i++) begin
      gnt_q.push_back(4'b1000);
      #1;
      exp_g = gnt_q.pop_front();
      n_checks++;
      if (bus.req_grant !== exp_g) begin
        n_fail++;
        $display("FAIL skip_grant%0d: got %b want %b", i, bus.req_grant, exp_g);
      end
      tick();
    end
    bus.req_valid[3] = 1'b0;
    bus.rel_valid    = 1'b1;
    bus.rel_chan     = 2'd2;
    bus.rel_done     = 1'b1;
    bus.rel_hdr      = 9'd1;
    gnt_q.push_back(4'b0000);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL capped_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    bus.rel_valid = 1'b0;
    bus.rel_done  = 1'b0;
    bus.rel_hdr   = '0;
    n_checks++;
    if (ch_outst[2] !== 7'd63 || avail_hdr !== 9'd191) begin
      n_fail++;
      $display("FAIL done_cnt: got %0d/%0d want 63/191",
               ch_outst[2], avail_hdr);
    end
    gnt_q.push_back(4'b0100);
    #1;
    exp_g = gnt_q.pop_front();
    n_checks++;
    if (bus.req_grant !== exp_g) begin
      n_fail++;
      $display("FAIL reelig_grant: got %b want %b", bus.req_grant, exp_g);
    end
    tick();
    clear_in();
    n_checks++;
    if (ch_outst[2] !== 7'd64 || avail_hdr !== 9'd190) begin
      n_fail++;
      $display("FAIL reelig_cnt: got %0d/%0d want 64/190",
               ch_outst[2], avail_hdr);
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 2'd0;
    bus.rel_hdr   = 9'd1;
    tick();
    clear_in();
    n_checks++;
    if (avail_hdr !== 9'd256 || avail_data !== 11'd1024
        || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got %0d/%0d/%b want 256/1024/1",
               avail_hdr, avail_data, err_overflow);
    end
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL early_unf: got %b want 0", err_underflow);
    end
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 2'd1;
    bus.rel_done  = 1'b1;
    tick();
    clear_in();
    tick();
    tick();
    n_checks++;
    if (err_underflow !== 1'b1 || ch_outst[1] !== 7'd0) begin
      n_fail++;
      $display("FAIL underflow: got %b/%0d want 1/0",
               err_underflow, ch_outst[1]);
    end
    n_checks++;
    if (err_overflow !== 1'b1 || err_oversize !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky: got ovf %b osz %b want 1/0",
               err_overflow, err_oversize);
    end
  endtask

  task automatic test_oversize_reset();
    do_reset();
    bus.req_valid   = 4'b0011;
    bus.req_hdr[0]  = 9'd1;
    bus.req_data[0] = 11'd1025;
    bus.req_hdr[1]  = 9'd2;
    bus.req_data[1] = 11'd8;
    for (int i = 0; i < 3; i++) begin
      gnt_q.push_back(4'b0010);
      #1;
      exp_g = gnt_q.pop_front();
      n_checks++;
      if (bus.req_grant !== exp_g) begin
        n_fail++;
        $display("FAIL osz_grant%0d: got %b want %b", i, bus.req_grant, exp_g);
      end
      tick();
    end
    n_checks++;
    if (err_oversize !== 1'b1 || ch_outst[0] !== 7'd0
        || ch_outst[1] !== 7'd3) begin
      n_fail++;
      $display("FAIL osz_state: got %b/%0d/%0d want 1/0/3",
               err_oversize, ch_outst[0], ch_outst[1]);
    end
    n_checks++;
    if (avail_hdr !== 9'd250 || avail_data !== 11'd1000) begin
      n_fail++;
      $display("FAIL osz_avail: got %0d/%0d want 250/1000",
               avail_hdr, avail_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_grant: got %b want 0000", bus.req_grant);
    end
    tick();
    n_checks++;
    if (avail_hdr !== 9'd256 || avail_data !== 11'd1024
        || ch_outst !== '0 || err_oversize !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got %0d/%0d/%h/%b want 256/1024/0/0",
               avail_hdr, avail_data, ch_outst, err_oversize);
    end
    clear_in();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_release_timing();
    test_outst_cap();
    test_errors();
    test_oversize_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
